// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronizer plus stability-qualifying FSM for a bouncing level input
module button_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic CLK,
  input  logic RST,
  input  logic signal_in,
  output logic signal_out,
  output logic busy
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   out_nxt, busy_nxt;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync       <= '0;
      state      <= STABLE_LOW;
      cnt        <= '0;
      signal_out <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], signal_in};
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      signal_out <= out_nxt;
      busy       <= busy_nxt;
    end
  end

  // Any return of s to the settled level abandons the candidate with no partial credit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_nxt   = signal_out;
    busy_nxt  = busy;
    unique case (state)
      STABLE_LOW: begin
        if (s) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_nxt = STABLE_LOW;
          cnt_nxt   = '0;
          busy_nxt  = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_HIGH;
          cnt_nxt   = '0;
          out_nxt   = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STABLE_HIGH: begin
        if (!s) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_nxt = STABLE_HIGH;
          cnt_nxt   = '0;
          busy_nxt  = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_LOW;
          cnt_nxt   = '0;
          out_nxt   = 1'b0;
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = STABLE_LOW;
        cnt_nxt   = '0;
        out_nxt   = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed and randomized checks against a run-length reference model
module tb_button_debouncer;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic signal_in = 1'b0;
  logic signal_out;
  logic busy;

  int compared   = 0;
  int mismatched = 0;

  button_debouncer #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .signal_in (signal_in),
    .signal_out(signal_out),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  // Reference: signal_in delayed SYNC edges, output flips after DEB+1 consecutive disagreeing samples.
  logic hist[$];
  logic m_out;
  int   m_run;
  int   cyc;
  int   last_change;

  task automatic check(input string tag, input logic obs, input logic exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
    m_out = 1'b0;
    m_run = 0;
  endtask

  task automatic step(input logic r, input logic v, input string tag);
    logic s;
    logic prev;
    @(negedge CLK);
    RST       = r;
    signal_in = v;
    prev      = signal_out;
    @(posedge CLK);
    cyc++;
    if (r) begin
      model_reset();
    end else begin
      s = hist.pop_front();
      hist.push_back(v);
      if (s != m_out) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_out = ~m_out;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    #1;
    check({tag, "_out"}, signal_out, m_out);
    check({tag, "_busy"}, busy, m_run > 0);
    if (!r && signal_out !== prev) begin
      if (last_change >= 0) check({tag, "_gap"}, (cyc - last_change) >= DEB + 1, 1'b1);
      last_change = cyc;
    end
    if (r) last_change = -1;
  endtask

  initial begin
    logic lvl;
    int   len;
    cyc         = 0;
    last_change = -1;
    model_reset();

    // Reset held with input high; outputs stay low throughout.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, "rst");
      check("rst_out_const", signal_out, 1'b0);
      check("rst_busy_const", busy, 1'b0);
    end
    for (int e = 0; e <= 6; e++) begin
      step(1'b0, 1'b1, "post_rst");
      check("post_rst_rise_edge", signal_out, e >= 6);
    end

    // Clean fall from high.
    for (int e = 0; e <= 7; e++) begin
      step(1'b0, 1'b0, "fall");
      check("fall_edge", signal_out, !(e >= 6));
    end

    // Clean rise: busy window and output edge.
    for (int e = 0; e <= 7; e++) begin
      step(1'b0, 1'b1, "rise");
      check("rise_out_edge", signal_out, e >= 6);
      check("rise_busy_edge", busy, e >= 2 && e < 6);
    end

    // Falling-side bounce 0,1,0,1 then 0 held.
    for (int e = 0; e <= 11; e++) begin
      step(1'b0, (e < 4) ? logic'(e % 2) : 1'b0, "fbounce");
      check("fbounce_edge", signal_out, !(e >= 10));
    end

    // Glitch: three high samples never reach the output.
    for (int e = 0; e <= 9; e++) begin
      step(1'b0, e <= 2, "glitch");
      check("glitch_out", signal_out, 1'b0);
      check("glitch_busy", busy, e >= 2 && e <= 4);
    end

    // Rising bounce 1,0,1,0 then 1 held.
    for (int e = 0; e <= 11; e++) begin
      step(1'b0, (e < 4) ? logic'((e + 1) % 2) : 1'b1, "rbounce");
      check("rbounce_edge", signal_out, e >= 10);
    end

    for (int e = 0; e < 8; e++) step(1'b0, 1'b0, "settle");
    check("settle_low", signal_out, 1'b0);

    // Reset in the middle of WAIT_HIGH restarts full qualification.
    for (int e = 0; e <= 12; e++) begin
      step(e == 4, 1'b1, "midrst");
      check("midrst_out_edge", signal_out, e >= 11);
      if (e == 4) check("midrst_busy_cleared", busy, 1'b0);
    end

    // Randomized runs of varying length with occasional resets.
    for (int n = 0; n < 600; n++) begin
      lvl = logic'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++) begin
        step(($urandom_range(0, 199) == 0), lvl, "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
